// File: rtl/fix_parser_field_ctrl.sv
// FIX byte-stream front end: strips '='/SOH, strobes tag/value bytes, frames messages, checks checksum.
// All outputs registered one cycle after the accepted byte; ready drops for the single post-checksum cycle.
module fix_parser_field_ctrl #(
  parameter int         MAX_TAG_LEN   = 4,
  parameter int         MAX_VALUE_LEN = 32,
  parameter logic [7:0] SOH_CHAR      = 8'h01,
  parameter logic [7:0] EQ_CHAR       = 8'h3D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [7:0]  data_o,
  output logic        start_tag_o,
  output logic        start_value_o,
  output logic [13:0] tag_num_o,
  output logic        field_done_o,
  output logic        msg_start_o,
  output logic        msg_end_o,
  output logic        checksum_ok_o,
  output logic        error_o
);

  localparam int TLW = $clog2(MAX_TAG_LEN + 1);
  localparam int VLW = $clog2(MAX_VALUE_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TAG,
    S_VALUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic             in_msg, in_msg_nx;
  logic [7:0]       sum, sum_nx;
  logic [7:0]       base, base_nx;
  logic [13:0]      tag_num, tag_num_nx;
  logic [TLW-1:0]   tag_len, tag_len_nx;
  logic [VLW-1:0]   val_len, val_len_nx;
  logic [9:0]       val_num, val_num_nx;
  logic             val_digits, val_digits_nx;
  logic             ok_pend, ok_pend_nx;

  logic [7:0]       data_nx;
  logic             ready_nx, tag_stb_nx, val_stb_nx;
  logic             field_done_nx, msg_start_nx, msg_end_nx, checksum_ok_nx, error_nx;

  logic             accept;
  logic             is_digit;
  logic [3:0]       digit;
  logic [13:0]      tag_mac;
  logic [9:0]       val_mac;

  assign accept    = in_valid_i & in_ready_o;
  assign is_digit  = (data_i >= 8'h30) && (data_i <= 8'h39);
  assign digit     = data_i[3:0];
  assign tag_mac   = tag_num * 14'd10 + {10'd0, digit};
  assign val_mac   = val_num * 10'd10 + {6'd0, digit};
  assign tag_num_o = tag_num;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      in_msg        <= 1'b0;
      sum           <= '0;
      base          <= '0;
      tag_num       <= '0;
      tag_len       <= '0;
      val_len       <= '0;
      val_num       <= '0;
      val_digits    <= 1'b0;
      ok_pend       <= 1'b0;
      in_ready_o    <= 1'b1;
      data_o        <= '0;
      start_tag_o   <= 1'b0;
      start_value_o <= 1'b0;
      field_done_o  <= 1'b0;
      msg_start_o   <= 1'b0;
      msg_end_o     <= 1'b0;
      checksum_ok_o <= 1'b0;
      error_o       <= 1'b0;
    end else begin
      state         <= state_nx;
      in_msg        <= in_msg_nx;
      sum           <= sum_nx;
      base          <= base_nx;
      tag_num       <= tag_num_nx;
      tag_len       <= tag_len_nx;
      val_len       <= val_len_nx;
      val_num       <= val_num_nx;
      val_digits    <= val_digits_nx;
      ok_pend       <= ok_pend_nx;
      in_ready_o    <= ready_nx;
      data_o        <= data_nx;
      start_tag_o   <= tag_stb_nx;
      start_value_o <= val_stb_nx;
      field_done_o  <= field_done_nx;
      msg_start_o   <= msg_start_nx;
      msg_end_o     <= msg_end_nx;
      checksum_ok_o <= checksum_ok_nx;
      error_o       <= error_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    in_msg_nx      = in_msg;
    sum_nx         = sum;
    base_nx        = base;
    tag_num_nx     = tag_num;
    tag_len_nx     = tag_len;
    val_len_nx     = val_len;
    val_num_nx     = val_num;
    val_digits_nx  = val_digits;
    ok_pend_nx     = ok_pend;
    data_nx        = data_o;
    tag_stb_nx     = 1'b0;
    val_stb_nx     = 1'b0;
    field_done_nx  = 1'b0;
    msg_start_nx   = 1'b0;
    msg_end_nx     = 1'b0;
    checksum_ok_nx = 1'b0;
    error_nx       = 1'b0;

    if (accept) begin
      sum_nx  = sum + data_i;
      data_nx = data_i;
    end

    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_digit) begin
            state_nx   = S_TAG;
            tag_num_nx = {10'd0, digit};
            tag_len_nx = TLW'(1);
            base_nx    = sum;
            tag_stb_nx = 1'b1;
          end else begin
            error_nx  = 1'b1;
            in_msg_nx = 1'b0;
            state_nx  = S_DRAIN;
          end
        end
      end

      S_TAG: begin
        if (accept) begin
          if (is_digit && (tag_len != TLW'(MAX_TAG_LEN))) begin
            tag_num_nx = tag_mac;
            tag_len_nx = tag_len + TLW'(1);
            tag_stb_nx = 1'b1;
          end else if (data_i == EQ_CHAR) begin
            state_nx      = S_VALUE;
            val_len_nx    = '0;
            val_num_nx    = '0;
            val_digits_nx = 1'b1;
          end else begin
            error_nx  = 1'b1;
            in_msg_nx = 1'b0;
            state_nx  = S_DRAIN;
          end
        end
      end

      S_VALUE: begin
        if (accept) begin
          if (data_i != SOH_CHAR) begin
            if (val_len == VLW'(MAX_VALUE_LEN)) begin
              error_nx  = 1'b1;
              in_msg_nx = 1'b0;
              state_nx  = S_DRAIN;
            end else begin
              val_stb_nx    = 1'b1;
              val_len_nx    = val_len + VLW'(1);
              val_num_nx    = val_mac;
              val_digits_nx = val_digits & is_digit;
            end
          end else begin
            state_nx = S_IDLE;
            if (val_len == '0) begin
              error_nx  = 1'b1;
              in_msg_nx = 1'b0;
            end else if (tag_num == 14'd8) begin
              // sum - base is exactly this field's bytes so far: restart the message sum from it
              msg_start_nx  = 1'b1;
              error_nx      = in_msg;
              field_done_nx = ~in_msg;
              in_msg_nx     = 1'b1;
              sum_nx        = sum + data_i - base;
            end else if (!in_msg) begin
              error_nx = 1'b1;
            end else if (tag_num == 14'd10) begin
              field_done_nx = 1'b1;
              ok_pend_nx    = (val_len == VLW'(3)) && val_digits && (val_num == {2'b00, base});
              state_nx      = S_DONE;
            end else begin
              field_done_nx = 1'b1;
            end
          end
        end
      end

      S_DRAIN: begin
        if (accept && (data_i == SOH_CHAR)) begin
          state_nx = S_IDLE;
        end
      end

      S_DONE: begin
        msg_end_nx     = 1'b1;
        checksum_ok_nx = ok_pend;
        in_msg_nx      = 1'b0;
        state_nx       = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase

    ready_nx = (state_nx != S_DONE);
  end

endmodule

// File: tb/tb_fix_parser_field_ctrl.sv
// Bench for fix_parser_field_ctrl: field-level reference model checked every cycle plus directed literal checks.
module tb_fix_parser_field_ctrl;

  localparam int         MAXT = 4;
  localparam int         MAXV = 32;
  localparam logic [7:0] SOH  = 8'h01;
  localparam logic [7:0] EQ   = 8'h3D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_i = 8'h00;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [7:0]  data_o;
  logic        start_tag_o, start_value_o;
  logic [13:0] tag_num_o;
  logic        field_done_o, msg_start_o, msg_end_o, checksum_ok_o, error_o;

  always #5 clk = ~clk;

  fix_parser_field_ctrl #(
    .MAX_TAG_LEN(MAXT), .MAX_VALUE_LEN(MAXV), .SOH_CHAR(SOH), .EQ_CHAR(EQ)
  ) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .data_o(data_o), .start_tag_o(start_tag_o), .start_value_o(start_value_o),
    .tag_num_o(tag_num_o), .field_done_o(field_done_o), .msg_start_o(msg_start_o),
    .msg_end_o(msg_end_o), .checksum_ok_o(checksum_ok_o), .error_o(error_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: works on whole fields held in queues.
  logic [7:0] m_tag[$], m_val[$], m_fb[$], m_msg[$];
  bit         m_skip = 0, m_eq = 0, m_inmsg = 0, m_pend = 0, m_pok = 0;
  bit         exp_ready = 1, exp_tag = 0, exp_val = 0, exp_fd = 0, exp_ms = 0;
  bit         exp_me = 0, exp_ck = 0, exp_err = 0, exp_tagchk = 1;
  logic [7:0] exp_data = 8'h00;
  int         exp_tagnum = 0;

  function automatic bit is_dig(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic int tag_value();
    int v = 0;
    foreach (m_tag[i]) v = v * 10 + int'(m_tag[i]) - 48;
    return v;
  endfunction

  task automatic new_field();
    m_eq = 0;
    m_tag.delete();
    m_val.delete();
    m_fb.delete();
  endtask

  task automatic to_drain();
    exp_err = 1;
    m_skip  = 1;
    m_inmsg = 0;
    new_field();
  endtask

  task automatic model_reset();
    exp_ready = 1; exp_tagchk = 1; exp_tagnum = 0; exp_data = 8'h00;
    m_skip = 0; m_inmsg = 0; m_pend = 0; m_pok = 0;
    m_msg.delete();
    new_field();
  endtask

  task automatic model_byte(input logic [7:0] b);
    int  t, want, vn;
    bit  alld;
    if (m_skip) begin
      if (b == SOH) m_skip = 0;
    end else begin
      m_fb.push_back(b);
      if (!m_eq) begin
        if (is_dig(b) && m_tag.size() < MAXT) begin
          m_tag.push_back(b);
          exp_tag = 1; exp_data = b; exp_tagchk = 0;
        end else if (b == EQ && m_tag.size() > 0) begin
          m_eq = 1; exp_tagchk = 1; exp_tagnum = tag_value();
        end else begin
          to_drain();
        end
      end else if (b != SOH) begin
        if (m_val.size() == MAXV) to_drain();
        else begin
          m_val.push_back(b);
          exp_val = 1; exp_data = b;
        end
      end else begin
        t = tag_value();
        if (m_val.size() == 0) begin
          exp_err = 1; m_inmsg = 0;
        end else if (t == 8) begin
          exp_ms = 1;
          if (m_inmsg) exp_err = 1; else exp_fd = 1;
          m_inmsg = 1;
          m_msg = m_fb;
        end else if (!m_inmsg) begin
          exp_err = 1;
        end else if (t == 10) begin
          want = 0;
          foreach (m_msg[i]) want += int'(m_msg[i]);
          want = want % 256;
          alld = 1; vn = 0;
          foreach (m_val[i]) begin
            if (!is_dig(m_val[i])) alld = 0;
            vn = vn * 10 + int'(m_val[i]) - 48;
          end
          m_pok = (m_val.size() == 3) && alld && (vn == want);
          m_pend = 1; exp_fd = 1; exp_ready = 0; m_inmsg = 0;
        end else begin
          exp_fd = 1;
          foreach (m_fb[i]) m_msg.push_back(m_fb[i]);
        end
        new_field();
      end
    end
  endtask

  always @(posedge clk) begin
    exp_tag = 0; exp_val = 0; exp_fd = 0; exp_ms = 0; exp_me = 0; exp_ck = 0; exp_err = 0;
    if (rst) model_reset();
    else if (m_pend) begin
      exp_me = 1; exp_ck = m_pok; m_pend = 0; exp_ready = 1;
    end else if (in_valid_i && exp_ready) model_byte(data_i);
  end

  // Observed-event counters, updated only from tick().
  int cnt_ms = 0, cnt_me = 0, cnt_ok = 0, cnt_fd = 0, cnt_err = 0, cnt_rl = 0, cnt_val = 0;
  int last_fd_tag = 0;
  logic [7:0] tlog[$], vlog[$];
  int b_ms, b_me, b_ok, b_fd, b_err, b_rl, b_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("in_ready", in_ready_o, exp_ready);
    chk("start_tag", start_tag_o, exp_tag);
    chk("start_value", start_value_o, exp_val);
    chk("field_done", field_done_o, exp_fd);
    chk("msg_start", msg_start_o, exp_ms);
    chk("msg_end", msg_end_o, exp_me);
    chk("checksum_ok", checksum_ok_o, exp_ck);
    chk("error", error_o, exp_err);
    if (exp_tag || exp_val) chk("data", data_o, exp_data);
    if (exp_tagchk) chk("tag_num", tag_num_o, exp_tagnum);
    if (msg_start_o) cnt_ms++;
    if (msg_end_o) cnt_me++;
    if (msg_end_o && checksum_ok_o) cnt_ok++;
    if (field_done_o) begin cnt_fd++; last_fd_tag = int'(tag_num_o); end
    if (error_o) cnt_err++;
    if (!in_ready_o) cnt_rl++;
    if (start_value_o) begin cnt_val++; vlog.push_back(data_o); end
    if (start_tag_o) tlog.push_back(data_o);
  endtask

  task automatic snap();
    b_ms = cnt_ms; b_me = cnt_me; b_ok = cnt_ok; b_fd = cnt_fd;
    b_err = cnt_err; b_rl = cnt_rl; b_val = cnt_val;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int w = 0;
    in_valid_i = 1'b1;
    data_i = b;
    while (!in_ready_o && w < 10) begin tick(); w++; end
    checks++;
    if (w >= 10) begin failures++; $display("FAIL ready_wait actual=0 required=1"); end
    tick();
    repeat (gap) begin in_valid_i = 1'b0; tick(); end
  endtask

  // '|' in a stimulus string stands for SOH.
  task automatic send_str(input string s, input int gap);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == 8'h7C) c = SOH;
      send(c, gap);
    end
  endtask

  task automatic idle(input int n);
    in_valid_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    in_valid_i = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int tb0, vb0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ready", in_ready_o, 1);
    chk("rst_error", error_o, 0);
    chk("rst_tag_num", tag_num_o, 0);
    rst = 1'b0;

    // 1: good checksum ('8'+'='+'A'+SOH = 183)
    snap(); send_str("8=A|10=183|", 0); idle(4);
    chk("s1_msg_start", cnt_ms - b_ms, 1);
    chk("s1_msg_end", cnt_me - b_me, 1);
    chk("s1_cksum_ok", cnt_ok - b_ok, 1);
    chk("s1_ready_low", cnt_rl - b_rl, 1);
    chk("s1_error", cnt_err - b_err, 0);
    chk("s1_field_done", cnt_fd - b_fd, 2);

    // 2: bad checksum
    snap(); send_str("8=A|10=184|", 0); idle(4);
    chk("s2_msg_end", cnt_me - b_me, 1);
    chk("s2_cksum_ok", cnt_ok - b_ok, 0);
    chk("s2_error", cnt_err - b_err, 0);

    // 3: ordinary field inside a message
    snap(); tb0 = tlog.size(); vb0 = vlog.size();
    send_str("8=A|35=D|", 0); idle(3);
    chk("s3_field_done", cnt_fd - b_fd, 2);
    chk("s3_tag_b0", tlog[tb0 + 1], 8'h33);
    chk("s3_tag_b1", tlog[tb0 + 2], 8'h35);
    chk("s3_val_b", vlog[vb0 + 1], 8'h44);
    chk("s3_tag_num", last_fd_tag, 35);

    // 4: tag too long, drained, then a fresh message
    do_reset(); snap();
    send_str("8=A|12345=X|8=A|", 0); idle(3);
    chk("s4_error", cnt_err - b_err, 1);
    chk("s4_msg_start", cnt_ms - b_ms, 2);
    chk("s4_field_done", cnt_fd - b_fd, 2);
    chk("s4_values", cnt_val - b_val, 2);

    // 6: gaps of 3 between bytes
    do_reset(); snap();
    send_str("8=A|10=183|", 3); idle(4);
    chk("s6_msg_start", cnt_ms - b_ms, 1);
    chk("s6_msg_end", cnt_me - b_me, 1);
    chk("s6_cksum_ok", cnt_ok - b_ok, 1);
    chk("s6_ready_low", cnt_rl - b_rl, 1);
    chk("s6_error", cnt_err - b_err, 0);

    // reset in the middle of a value
    send_str("8=A|35=DE", 0);
    in_valid_i = 1'b1; data_i = 8'h46; rst = 1'b1;
    tick();
    chk("mid_rst_value", start_value_o, 0);
    chk("mid_rst_ready", in_ready_o, 1);
    chk("mid_rst_tag_num", tag_num_o, 0);
    chk("mid_rst_data", data_o, 0);
    rst = 1'b0; in_valid_i = 1'b0;

    // 5: non-8 first field outside a message
    snap(); send_str("35=D|", 0); idle(3);
    chk("s5_error", cnt_err - b_err, 1);
    chk("s5_msg_start", cnt_ms - b_ms, 0);
    chk("s5_field_done", cnt_fd - b_fd, 0);

    // boundaries: 4-digit tag and 32-byte value accepted, 33rd value byte rejected
    do_reset(); snap();
    send_str("8=A|1234=", 0);
    for (int i = 0; i < MAXV; i++) send(8'h78, 0);
    send_str("|", 0); idle(2);
    chk("b_error", cnt_err - b_err, 0);
    chk("b_field_done", cnt_fd - b_fd, 2);
    chk("b_values", cnt_val - b_val, MAXV + 1);
    chk("b_tag_num", last_fd_tag, 1234);
    snap();
    send_str("58=", 0);
    for (int i = 0; i <= MAXV; i++) send(8'h79, 0);
    send_str("|", 0); idle(2);
    chk("b33_error", cnt_err - b_err, 1);
    chk("b33_values", cnt_val - b_val, MAXV);
    chk("b33_field_done", cnt_fd - b_fd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
